instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-002 Parameter MAX_WAIT, default 16, SHALL set the maximum cycles to wait for imem_ack before flagging a timeout.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 imem_req  output  1  SHALL be the fetch request to instruction memory.
REQ-006 imem_addr  output  32  SHALL be the fetch address; equals pc while imem_req=1.
REQ-007 imem_rdata  input  32  SHALL be the instruction word, valid in the cycle imem_ack=1.
REQ-008 imem_ack  input  1  SHALL be the memory response strobe.
REQ-009 instr  output  32  SHALL be the fetched instruction, driving the immediate generator and decoder.
REQ-010 pc  output  32  SHALL be the address of instr.
REQ-011 instr_valid  output  1  SHALL indicate that instr/pc hold a fetched instruction.
REQ-012 stall  input  1  SHALL indicate that downstream cannot consume instr this cycle.
REQ-013 branch_taken, jal, jalr  input  1 each  SHALL be redirect requests from decode/ALU.
REQ-014 imm  input  32  SHALL be the sign-extended immediate from the immediate generator.
REQ-015 rs1_val  input  32  SHALL be the rs1 register value used for JALR.
REQ-016 fetch_err  output  1  SHALL flag a sticky fault; err_code  output  2  SHALL give its cause (01 misaligned target, 10 timeout).

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, HOLD and ERROR.
REQ-018 IDLE SHALL last exactly one cycle after reset is released, then go to FETCH.
REQ-019 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; on imem_ack=1, instr SHALL be loaded from imem_rdata and the FSM SHALL go to HOLD.
REQ-020 In FETCH, a wait counter SHALL increment each cycle without ack; reaching MAX_WAIT SHALL go to ERROR with err_code=10.
REQ-021 instr_valid SHALL be 1 exactly in HOLD; imem_ack outside FETCH SHALL be ignored.
REQ-022 In HOLD with stall=1, instr and pc SHALL stay stable and redirect inputs SHALL be ignored.
REQ-023 In HOLD with stall=0, next PC SHALL be chosen with priority jalr > jal > branch_taken > sequential.
REQ-024 The candidate next-PC values SHALL be: jalr (rs1_val+imm)&~1; jal or branch pc+imm; otherwise pc+4.
REQ-025 All adds SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 SHALL wrap to 0.
REQ-026 A next PC with bits[1:0]≠00 SHALL go to ERROR with err_code=01, leaving pc unchanged; otherwise pc SHALL update and the FSM SHALL go to FETCH.
REQ-027 Fetch latency SHALL be 1 cycle from entering FETCH to the earliest HOLD (ack in the same cycle as the request).
REQ-028 ERROR SHALL be absorbing until rst; in ERROR, imem_req=0, instr_valid=0 and fetch_err=1.

Reset
REQ-029 While rst=1, all of the following SHALL hold asynchronously: state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, imem_req=0, fetch_err=0, err_code=00, wait counter=0.
REQ-030 Reset asserted mid-FETCH SHALL drop imem_req immediately; any late ack after release SHALL be ignored until the next FETCH.

Structure
REQ-031 A shared package rv_fetch_pkg SHALL hold the FSM state enum, the err_code constants, the NOP encoding and the opcode constants (LOAD 3, OP_IMM 19, AUIPC 23, STORE 35, LUI 55, BRANCH 99, JALR 103, JAL 111).
REQ-032 A combinational sub-module next_pc_calc SHALL implement REQ-023 to REQ-025 and output the next PC plus a misaligned flag.

Verification
REQ-033 Reset, then ack in the same cycle as each request, stall=0 -> pc sequence 0,4,8,C with instr_valid pulsing every other cycle.
REQ-034 pc=0x100, imm=0xFFFF_FFF0, branch_taken=1 -> next fetch address 0xF0.
REQ-035 rs1_val=0x203, imm=4, jalr=1 and jal=1 together -> next address 0x206, fetch_err=1, err_code=01, imem_req stays 0.
REQ-036 Hold ack low for 16 cycles with MAX_WAIT=16 -> fetch_err=1, err_code=10; ack afterwards has no effect.
REQ-037 stall=1 for 5 cycles in HOLD with jal toggling -> instr/pc stable; jal=1 with imm=8 at release -> pc+8.
REQ-038 Assert rst mid-FETCH -> imem_req=0 the same cycle; after release pc=RESET_PC and instr=0x0000_0013.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv_fetch_pkg : shared types and constants for the fetch stage        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rv_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ERROR = 2'd3
    } fetch_state_t;

    localparam logic [1:0]  ERR_NONE     = 2'b00;
    localparam logic [1:0]  ERR_MISALIGN = 2'b01;
    localparam logic [1:0]  ERR_TIMEOUT  = 2'b10;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    localparam logic [6:0]  OPC_LOAD     = 7'd3;
    localparam logic [6:0]  OPC_OP_IMM   = 7'd19;
    localparam logic [6:0]  OPC_AUIPC    = 7'd23;
    localparam logic [6:0]  OPC_STORE    = 7'd35;
    localparam logic [6:0]  OPC_LUI      = 7'd55;
    localparam logic [6:0]  OPC_BRANCH   = 7'd99;
    localparam logic [6:0]  OPC_JALR     = 7'd103;
    localparam logic [6:0]  OPC_JAL      = 7'd111;

endpackage
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | next_pc_calc : redirect-priority next-PC selection, misalign flag    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module next_pc_calc (
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    input  logic        branch_taken,
    input  logic        jal,
    input  logic        jalr,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] w_jalr_sum;

    assign w_jalr_sum = rs1_val + imm;

    always_comb begin
        next_pc = pc + 32'd4;
        if (jalr) begin
            next_pc = {w_jalr_sum[31:1], 1'b0};
        end else if (jal || branch_taken) begin
            next_pc = pc + imm;
        end
    end

    assign misaligned = |next_pc[1:0];

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch : single-outstanding instruction fetch with redirects    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instr_fetch
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    output logic        fetch_err,
    output logic [1:0]  err_code
);

    // Counter only needs to reach MAX_WAIT-1: the cycle that would hit MAX_WAIT leaves FETCH.
    localparam int             WCW         = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [WCW-1:0] c_wait_last = WCW'(MAX_WAIT - 1);

    fetch_state_t   r_state, w_state_nxt;
    logic [31:0]    r_pc, w_pc_nxt;
    logic [31:0]    r_instr, w_instr_nxt;
    logic [1:0]     r_err, w_err_nxt;
    logic [WCW-1:0] r_wait, w_wait_nxt;
    logic [31:0]    w_next_pc;
    logic           w_misaligned;
    logic           w_req;
    logic           w_valid;
    logic           w_fetch_err;

    next_pc_calc u_next_pc_calc (
        .pc           (r_pc),
        .imm          (imm),
        .rs1_val      (rs1_val),
        .branch_taken (branch_taken),
        .jal          (jal),
        .jalr         (jalr),
        .next_pc      (w_next_pc),
        .misaligned   (w_misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_err   <= ERR_NONE;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_err   <= w_err_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_err_nxt   = r_err;
        w_wait_nxt  = r_wait;
        w_req       = 1'b0;
        w_valid     = 1'b0;
        w_fetch_err = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
                w_wait_nxt  = '0;
            end
            ST_FETCH: begin
                w_req = 1'b1;
                if (imem_ack) begin
                    w_instr_nxt = imem_rdata;
                    w_wait_nxt  = '0;
                    w_state_nxt = ST_HOLD;
                end else if (r_wait == c_wait_last) begin
                    w_err_nxt   = ERR_TIMEOUT;
                    w_state_nxt = ST_ERROR;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            ST_HOLD: begin
                w_valid = 1'b1;
                if (!stall) begin
                    if (w_misaligned) begin
                        w_err_nxt   = ERR_MISALIGN;
                        w_state_nxt = ST_ERROR;
                    end else begin
                        w_pc_nxt    = w_next_pc;
                        w_state_nxt = ST_FETCH;
                    end
                end
            end
            ST_ERROR: begin
                w_fetch_err = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign pc          = r_pc;
    assign instr_valid = w_valid;
    assign fetch_err   = w_fetch_err;
    assign err_code    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_fetch : directed self-checking bench for instr_fetch        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic        jal;
    logic        jalr;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic        fetch_err;
    logic [1:0]  err_code;

    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ack     (imem_ack),
        .instr        (instr),
        .pc           (pc),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .branch_taken (branch_taken),
        .jal          (jal),
        .jalr         (jalr),
        .imm          (imm),
        .rs1_val      (rs1_val),
        .fetch_err    (fetch_err),
        .err_code     (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; imem_rdata = 32'h0; imem_ack = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; jal = 1'b0; jalr = 1'b0; imm = 32'h0; rs1_val = 32'h0;
        tick();
        check("rst_req",   {31'b0, imem_req},    32'h0);
        check("rst_pc",    pc,                   32'h0);
        check("rst_instr", instr,                32'h0000_0013);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_err",   {31'b0, fetch_err},   32'h0);
        check("rst_code",  {30'b0, err_code},    32'h0);
        rst = 1'b0;
        check("idle_req", {31'b0, imem_req}, 32'h0);

        // Sequential fetches with same-cycle ack
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_rdata = 32'hA000_0000 + i;
            tick();
            check("seq_req",   {31'b0, imem_req},    32'h1);
            check("seq_addr",  imem_addr,            32'(i * 4));
            check("seq_fvld",  {31'b0, instr_valid}, 32'h0);
            tick();
            check("seq_hvld",  {31'b0, instr_valid}, 32'h1);
            check("seq_pc",    pc,                   32'(i * 4));
            check("seq_instr", instr,                32'hA000_0000 + i);
        end
        // Ack during HOLD must not reload instr (stall keeps us in HOLD)
        stall = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("hold_ack_ign", instr, 32'hA000_0003);
        stall = 1'b0;

        // jal from 0xC to 0x100
        jal = 1'b1; imm = 32'h0000_00F4;
        tick();
        jal = 1'b0;
        check("jal_addr", imem_addr, 32'h0000_0100);
        imem_rdata = 32'h1111_1111;
        tick();
        check("jal_pc", pc, 32'h0000_0100);

        // Backward branch 0x100 + (-16) = 0xF0
        branch_taken = 1'b1; imm = 32'hFFFF_FFF0;
        tick();
        branch_taken = 1'b0;
        check("br_addr", imem_addr, 32'h0000_00F0);
        imem_rdata = 32'h2222_2222;
        tick();
        check("br_instr", instr, 32'h2222_2222);

        // Stall with jal toggling: pc/instr hold, redirects ignored
        stall = 1'b1; imm = 32'h0000_0008; imem_rdata = 32'h3333_3333;
        for (int i = 0; i < 5; i++) begin
            jal = i[0];
            tick();
            check("stall_pc",    pc,                   32'h0000_00F0);
            check("stall_instr", instr,                32'h2222_2222);
            check("stall_vld",   {31'b0, instr_valid}, 32'h1);
        end
        stall = 1'b0; jal = 1'b1;
        tick();
        jal = 1'b0;
        check("rel_addr", imem_addr, 32'h0000_00F8);
        tick();

        // jalr to 0xFFFF_FFFC then sequential wrap to 0
        jalr = 1'b1; rs1_val = 32'hFFFF_FFFD; imm = 32'h0000_0000;
        tick();
        jalr = 1'b0;
        check("jalr_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        check("wrap_addr", imem_addr, 32'h0000_0000);
        tick();

        // jalr beats jal; target 0x206 is misaligned
        jalr = 1'b1; jal = 1'b1; rs1_val = 32'h0000_0203; imm = 32'h0000_0004;
        tick();
        jalr = 1'b0; jal = 1'b0;
        check("mis_err",  {31'b0, fetch_err},   32'h1);
        check("mis_code", {30'b0, err_code},    32'h1);
        check("mis_pc",   pc,                   32'h0);
        tick();
        tick();
        check("mis_req",  {31'b0, imem_req},    32'h0);
        check("mis_vld",  {31'b0, instr_valid}, 32'h0);

        // Timeout: 16 FETCH cycles without ack
        imem_ack = 1'b0;
        do_reset();
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("to_still_req", {31'b0, imem_req}, 32'h1);
        tick();
        check("to_err",  {31'b0, fetch_err}, 32'h1);
        check("to_code", {30'b0, err_code},  32'h2);
        imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
        tick();
        tick();
        check("to_absorb", {31'b0, fetch_err},   32'h1);
        check("to_vld",    {31'b0, instr_valid}, 32'h0);
        check("to_instr",  instr,                32'h0000_0013);

        // Async reset mid-FETCH after a completed fetch
        do_reset();
        imem_rdata = 32'h5555_5555;
        tick();
        tick();
        tick();
        check("ar_pre_addr", imem_addr, 32'h4);
        imem_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("ar_req",   {31'b0, imem_req}, 32'h0);
        check("ar_pc",    pc,                32'h0);
        check("ar_instr", instr,             32'h0000_0013);
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h6666_6666;
        rst = 1'b0;
        tick();
        check("ar_late_instr", instr, 32'h0000_0013);
        check("ar_fetch_req",  {31'b0, imem_req}, 32'h1);
        check("ar_fetch_pc",   pc,                32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
